// File: rtl/arb_client.sv
// Requester-side agent: takes a burst command, requests the arbiter, and counts granted beats.
// Latency: req rises the cycle after command accept; done pulses the cycle after the final beat or abort.
// Backpressure: cmd_ready is high only in IDLE; gnt low in BUSY stalls beat counting until timeout.
module arb_client #(
  parameter int LEN_W   = 4,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             req,
  input  logic             gnt,
  output logic             beat,
  output logic [LEN_W:0]   beat_cnt,
  output logic             done,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Wait-counter value at which an un-granted cycle triggers the abort.
  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W:0]   beat_cnt_q, beat_cnt_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic             timeout_err_q, timeout_err_d;

  // Interface outputs decode the state register only, so gnt/cmd_valid never reach req/cmd_ready/done.
  assign req         = (state_q == S_BUSY);
  assign cmd_ready   = (state_q == S_IDLE);
  assign done        = (state_q == S_DONE);
  assign beat        = (state_q == S_BUSY) && gnt;
  assign beat_cnt    = beat_cnt_q;
  assign timeout_err = timeout_err_q;

  // Next-state and datapath: accept in IDLE, count beats or grant-wait cycles in BUSY, one DONE cycle.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    beat_cnt_d    = beat_cnt_q;
    wait_d        = wait_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d       = S_BUSY;
          remaining_d   = cmd_len;
          beat_cnt_d    = '0;
          wait_d        = '0;
          timeout_err_d = 1'b0;
        end
      end
      S_BUSY: begin
        if (gnt) begin
          // A beat always beats the timeout threshold on the same cycle.
          beat_cnt_d = beat_cnt_q + 1'b1;
          wait_d     = '0;
          if (remaining_q == '0) begin
            state_d = S_DONE;
          end else begin
            remaining_d = remaining_q - 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          timeout_err_d = 1'b1;
          wait_d        = '0;
          state_d       = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DONE: begin
        // Trailing grants here are ignored; req is low for this cycle.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      remaining_q   <= '0;
      beat_cnt_q    <= '0;
      wait_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      beat_cnt_q    <= beat_cnt_d;
      wait_q        <= wait_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_arb_client.sv
// Testbench for arb_client: scenario tasks plus randomized bursts against a burst-level reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Every wait on the design is bounded by a cycle budget, with a global time limit as a backstop.
module tb_arb_client;

  localparam int LEN_W   = 4;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_ready;
  logic             req;
  logic             gnt = 1'b0;
  logic             beat;
  logic [LEN_W:0]   beat_cnt;
  logic             done;
  logic             timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Grant pattern seen by the DUT on successive BUSY cycles, and the model's predictions.
  bit gpat [256];
  int exp_end;
  int exp_beats;
  bit exp_to;

  arb_client #(.LEN_W(LEN_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_len     (cmd_len),
    .cmd_ready   (cmd_ready),
    .req         (req),
    .gnt         (gnt),
    .beat        (beat),
    .beat_cnt    (beat_cnt),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Burst outcome from the rules: count granted cycles until len+1 beats, or abort
  // once TIMEOUT consecutive un-granted cycles have elapsed.
  function automatic void model(input int len);
    int b;
    int w;
    b = 0;
    w = 0;
    exp_to  = 1'b0;
    exp_end = 255;
    for (int i = 0; i < 256; i++) begin
      if (gpat[i]) begin
        b++;
        w = 0;
        if (b == len + 1) begin
          exp_end = i;
          break;
        end
      end else begin
        w++;
        if (w == TIMEOUT) begin
          exp_end = i;
          exp_to  = 1'b1;
          break;
        end
      end
    end
    exp_beats = b;
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL wait_ready: cmd_ready=%b after 20 cycles, want 1", cmd_ready);
    end
  endtask

  // Issue one command, drive gpat on BUSY cycles, trail0/trail1 on the DONE and following IDLE cycle.
  task automatic run_burst(input string tag, input int len, input bit trail0, input bit trail1);
    bit ok;
    int cnt;
    logic [9:0] obs;
    logic [9:0] expv;
    model(len);
    wait_ready(ok);
    if (!ok) return;
    cmd_len   = LEN_W'(len);
    cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i <= exp_end; i++) begin
      gnt = gpat[i];
      @(negedge clock);
      obs  = {req, cmd_ready, done, beat, timeout_err, beat_cnt};
      expv = {1'b1, 1'b0, 1'b0, gpat[i], 1'b0, 5'(cnt)};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL %s busy[%0d]: {req,rdy,done,beat,to,cnt} got %h want %h", tag, i, obs, expv);
      end
      if (gpat[i]) cnt++;
      @(posedge clock); #1;
    end
    gnt = trail0;
    @(negedge clock);
    obs  = {req, cmd_ready, done, beat, timeout_err, beat_cnt};
    expv = {1'b0, 1'b0, 1'b1, 1'b0, exp_to, 5'(exp_beats)};
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s done_cycle: {req,rdy,done,beat,to,cnt} got %h want %h", tag, obs, expv);
    end
    @(posedge clock); #1;
    gnt = trail1;
    @(negedge clock);
    obs  = {req, cmd_ready, done, beat, timeout_err, beat_cnt};
    expv = {1'b0, 1'b1, 1'b0, 1'b0, exp_to, 5'(exp_beats)};
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s idle_after: {req,rdy,done,beat,to,cnt} got %h want %h", tag, obs, expv);
    end
    gnt = 1'b0;
  endtask

  task automatic clear_pat(input bit v);
    for (int i = 0; i < 256; i++) gpat[i] = v;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    reset = 1'b0;
    gnt   = 1'b1;
    #3;
    obs = {req, cmd_ready, done, beat, timeout_err, beat_cnt};
    n_cmp++;
    if (obs !== 10'b0100000000) begin
      n_bad++;
      $display("FAIL reset_values: got %h want %h", obs, 10'b0100000000);
    end
    #5 reset = 1'b1;
    // Grant with no outstanding burst must be ignored.
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      obs = {req, cmd_ready, done, beat, timeout_err, beat_cnt};
      n_cmp++;
      if (obs !== 10'b0100000000) begin
        n_bad++;
        $display("FAIL idle_gnt[%0d]: got %h want %h", k, obs, 10'b0100000000);
      end
    end
    @(posedge clock); #1;
    gnt = 1'b0;
  endtask

  task automatic test_single_beat();
    clear_pat(1'b0);
    gpat[1] = 1'b1;
    run_burst("single", 0, 1'b1, 1'b0);
  endtask

  task automatic test_contention();
    clear_pat(1'b0);
    for (int i = 0; i < 8; i++) gpat[i] = (i % 2 == 0);
    run_burst("contend", 3, 1'b0, 1'b0);
  endtask

  task automatic test_trailing_grant();
    clear_pat(1'b1);
    run_burst("trail", 1, 1'b1, 1'b1);
  endtask

  task automatic test_timeout();
    clear_pat(1'b0);
    run_burst("timeout", 2, 1'b0, 1'b0);
    clear_pat(1'b0);
    gpat[2] = 1'b1;
    run_burst("timeout_restart", 2, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    logic [9:0] obs;
    wait_ready(ok);
    if (!ok) return;
    cmd_len   = 4'd7;
    cmd_valid = 1'b1;
    gnt       = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    obs = {req, beat, beat_cnt};
    n_cmp++;
    if (obs[6:0] !== 7'b1100001) begin
      n_bad++;
      $display("FAIL rst_mid_pre: {req,beat,cnt} got %h want %h", obs[6:0], 7'b1100001);
    end
    #1 reset = 1'b0;
    #1;
    obs = {req, cmd_ready, done, beat, timeout_err, beat_cnt};
    n_cmp++;
    if (obs !== 10'b0100000000) begin
      n_bad++;
      $display("FAIL rst_mid_async: got %h want %h", obs, 10'b0100000000);
    end
    gnt = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    clear_pat(1'b1);
    run_burst("after_reset", 2, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int prev;
    int n_acc;
    int gap_low;
    wait_ready(ok);
    if (!ok) return;
    cmd_len   = 4'd1;
    cmd_valid = 1'b1;
    gnt       = 1'b1;
    prev    = -1;
    n_acc   = 0;
    gap_low = 0;
    // First sample is the IDLE cycle already observed ready; accepts should recur every 4 cycles
    // (IDLE, 2 BUSY, DONE) with exactly one DONE cycle of low req between bursts.
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clock);
      if (cmd_ready) begin
        if (prev >= 0) begin
          n_cmp++;
          if (k - prev !== 4 || gap_low !== 1 || beat_cnt !== 5'd2) begin
            n_bad++;
            $display("FAIL b2b[%0d]: spacing %0d req_low %0d cnt %0d, want 4 1 2", k, k - prev, gap_low, beat_cnt);
          end
        end
        prev    = k;
        gap_low = 0;
        n_acc++;
      end else if (!req) begin
        gap_low++;
      end
      @(posedge clock); #1;
    end
    n_cmp++;
    if (n_acc !== 4) begin
      n_bad++;
      $display("FAIL b2b_accepts: got %0d want 4", n_acc);
    end
    cmd_valid = 1'b0;
    gnt       = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic test_random();
    int len;
    int pct;
    for (int r = 0; r < 16; r++) begin
      len = int'($urandom_range(0, 15));
      pct = int'($urandom_range(25, 95));
      for (int i = 0; i < 256; i++) gpat[i] = (int'($urandom_range(0, 99)) < pct);
      run_burst("random", len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_contention();
    test_trailing_grant();
    test_timeout();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
